stack_op_sequencer: RTL and testbench
=====================================

# stack_op_sequencer

Multi-cycle sequencer that drives the core's stack-pointer datapath (SPH:SPL incrementer/decrementer and SREG flag-write port) and the data-RAM port for stack traffic. It executes PUSH, POP, CALL, RET, IRQ-entry and RETI as byte-serial sequences, one byte per clock-enabled cycle, with AVR post-decrement push / pre-increment pop semantics. It sits between the instruction decoder/interrupt logic and the I/O register file / data RAM. It owns `sp_en`, `sp_ndown_up` and SREG bit 7 writes while busy.

## Interface
Parameters:
- `pc22b`, default 0: 0 → return address is 2 bytes (PC[15:0]); 1 → 3 bytes (PC[21:0]).

Ports:
- `cp2` in 1: core clock, rising edge.
- `ireset` in 1: asynchronous active-low reset.
- `cp2en` in 1: clock enable; state and counters advance only when 1.
- `op_valid` in 1: operation request.
- `op_code` in 3: 0 PUSH, 1 POP, 2 CALL, 3 RET, 4 IRQ, 5 RETI, 6/7 reserved.
- `op_ready` out 1: 1 only in IDLE.
- `pc_in` in 22: return address for CALL/IRQ; bits [21:16] ignored when pc22b=0.
- `push_data` in 8: byte for PUSH.
- `spl_in`, `sph_in` in 8 each: current SP from the register file.
- `sp_en` out 1: SP count enable.
- `sp_ndown_up` out 1: 0 = decrement, 1 = increment.
- `ram_adr` out 16: stack RAM address.
- `ram_we`, `ram_re` out 1 each: write and read strobes.
- `ram_dout` out 8: write data.
- `ram_din` in 8: read data, valid in the enabled cycle after `ram_re`.
- `pc_out` out 22: popped return address; [21:16]=0 when pc22b=0.
- `pc_load` out 1: `pc_out` valid (RET/RETI).
- `pop_data` out 8, `pop_valid` out 1: popped byte (POP).
- `sreg_fl_in`, `sreg_fl_wr_en` out 8 each: only bit 7 (I flag) is ever driven.
- `busy` out 1, `done` out 1.

## Operation
- **States:** IDLE, PUSH, POP, CAPT.
- **Accept (IDLE):** an op is taken when `op_valid` & `cp2en`. On the accept edge the block latches `op_code`, `pc_in` and `push_data`, and loads the byte counter n:
  - PUSH/POP: n = 1.
  - CALL/RET/IRQ/RETI: n = 2 + pc22b.
- **Reserved codes:** consumed with no side effects. `done` is not asserted.
- **PUSH state:** one byte per enabled cycle.
  - Drives `ram_adr` = {sph_in,spl_in}, `ram_we`=1, `sp_en`=1, `sp_ndown_up`=0.
  - Byte order: PC[7:0], PC[15:8], then PC[21:16] if pc22b (or `push_data` for PUSH).
  - On the last byte of IRQ, also drives `sreg_fl_wr_en[7]`=1, `sreg_fl_in[7]`=0.
  - After the last byte → IDLE.
- **POP state:** one byte per enabled cycle.
  - Drives `ram_adr` = {sph_in,spl_in}+1 (16-bit modular), `ram_re`=1, `sp_en`=1, `sp_ndown_up`=1.
  - Each `ram_din` arriving during POP is shifted into the assembly register.
  - Byte order: PC[21:16] (if pc22b), PC[15:8], PC[7:0].
  - After the last read → CAPT.
- **CAPT state:** one enabled cycle; no RAM or SP strobes.
  - Forms the result from the assembly register and `ram_din`.
  - RET/RETI: asserts `pc_load`. POP: asserts `pop_valid`.
  - RETI: also drives `sreg_fl_wr_en[7]`=1, `sreg_fl_in[7]`=1.
  - Then → IDLE.
- **Strobe gating:** all strobes (`ram_we`, `ram_re`, `sp_en`, `sreg_fl_wr_en`, `pc_load`, `pop_valid`) are combinational and qualified by `cp2en`. With `cp2en`=0 they are 0 and all state is held.
- **Status outputs:**
  - `busy` = (state ≠ IDLE).
  - `done` is registered. It is set on the enabled edge that returns to IDLE from a valid op and cleared on the next enabled edge.
- **Back-to-back ops:** a new op may be accepted in the same cycle `done`=1.
- **SP wrap:** SP arithmetic wraps modulo 2^16. 0x0000 push → SP 0xFFFF; pop read address 0xFFFF+1 = 0x0000. No range checks.
- **iowe exclusion:** the decoder never issues an I/O write to SPL/SPH/SREG while `busy`=1. The register file's iowe priority would otherwise drop `sp_en`.

## Timing
- **Reset values** (`ireset` low, immediate): state IDLE, `op_ready`=1, `busy`=0, `done`=0. All strobes 0. `ram_adr`/`ram_dout`/`pc_out`/`pop_data` = 0 outside active states, and the assembly register is 0.
- **Reset mid-operation:** abort to IDLE with no further strobes. SP is restored by the register file's own reset.
- **Latency** in enabled cycles after the accept edge:
  - PUSH: 1.
  - CALL/IRQ: 2 (3 with pc22b).
  - POP: 2.
  - RET/RETI: 3 (4 with pc22b).
  - `done` is high in the following cycle.
- **Disabled cycles:** `cp2en`=0 cycles stretch the sequence without reordering or repeating bytes.

## Test plan
- **CALL, pc22b=0:** reset (SP=0x04FF); CALL `pc_in`=0x001234 → writes 0x34@0x04FF then 0x12@0x04FE; SP=0x04FD; `done` 1 cycle.
- **RET after CALL:** reads at 0x04FE then 0x04FF; CAPT gives `pc_out`=0x001234 with `pc_load`=1; SP=0x04FF.
- **IRQ then RETI, pc22b=1, `pc_in`=0x2ABCDE:** writes DE, BC, 2A at 0x04FF..0x04FD; I cleared on the 3rd write. RETI → `pc_out`=0x2ABCDE, I set in CAPT.
- **SP wrap:** SP=0x0000, PUSH 0xA5 → write@0x0000, SP=0xFFFF. POP → read@0x0000, `pop_data`=0xA5, SP=0x0000.
- **cp2en stall:** `cp2en`=0 for 3 cycles between CALL bytes → strobes 0 while low; resumes with byte 0x12@0x04FE; exactly 2 writes total.
- **Reset mid-RET:** `ireset` low during POP → strobes 0 immediately, no `pc_load`. After release `op_ready`=1; reserved op_code 6 → no strobes, no `done`.

Source files
------------

// File: rtl/stack_op_sequencer_if.sv
// Stack sequencer bus: op request/handshake, SP datapath control, stack RAM port,
// popped-result and SREG I-flag outputs. Clock, reset and clock enable stay scalar ports.
interface stack_op_sequencer_if;
   logic        op_valid;
   logic [2:0]  op_code;
   logic        op_ready;
   logic [21:0] pc_in;
   logic [7:0]  push_data;
   logic [7:0]  spl_in;
   logic [7:0]  sph_in;
   logic        sp_en;
   logic        sp_ndown_up;
   logic [15:0] ram_adr;
   logic        ram_we;
   logic        ram_re;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic [21:0] pc_out;
   logic        pc_load;
   logic [7:0]  pop_data;
   logic        pop_valid;
   logic [7:0]  sreg_fl_in;
   logic [7:0]  sreg_fl_wr_en;
   logic        busy;
   logic        done;

   modport master (
      output op_valid, op_code, pc_in, push_data, spl_in, sph_in, ram_din,
      input  op_ready, sp_en, sp_ndown_up, ram_adr, ram_we, ram_re, ram_dout,
             pc_out, pc_load, pop_data, pop_valid, sreg_fl_in, sreg_fl_wr_en,
             busy, done
   );

   modport slave (
      input  op_valid, op_code, pc_in, push_data, spl_in, sph_in, ram_din,
      output op_ready, sp_en, sp_ndown_up, ram_adr, ram_we, ram_re, ram_dout,
             pc_out, pc_load, pop_data, pop_valid, sreg_fl_in, sreg_fl_wr_en,
             busy, done
   );
endinterface

// File: rtl/stack_op_sequencer.sv
// Byte-serial stack sequencer for PUSH/POP/CALL/RET/IRQ/RETI with AVR
// post-decrement push and pre-increment pop; one byte per enabled cycle.
module stack_op_sequencer #(
   parameter bit pc22b = 1'b0
) (
   input  logic                 cp2,
   input  logic                 ireset,
   input  logic                 cp2en,
   stack_op_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PUSH = 2'd1,
      S_POP  = 2'd2,
      S_CAPT = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_PUSH = 3'd0,
      OP_POP  = 3'd1,
      OP_CALL = 3'd2,
      OP_RET  = 3'd3,
      OP_IRQ  = 3'd4,
      OP_RETI = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } op_t;

   localparam logic [1:0] N_ADDR = pc22b ? 2'd3 : 2'd2;

   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic [23:0] sh_q, sh_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [13:0] asm_q, asm_d;
   logic        rd_pend_q, rd_pend_d;
   logic        done_q, done_d;

   logic [15:0] sp;
   logic [15:0] sp_inc;
   logic [23:0] pc_ext;
   op_t         op_req;

   logic        op_ready;
   logic        sp_en;
   logic        sp_ndown_up;
   logic [15:0] ram_adr;
   logic        ram_we;
   logic        ram_re;
   logic [7:0]  ram_dout;
   logic [21:0] pc_out;
   logic        pc_load;
   logic [7:0]  pop_data;
   logic        pop_valid;
   logic [7:0]  sreg_fl_in;
   logic [7:0]  sreg_fl_wr_en;

   assign sp     = {bus.sph_in, bus.spl_in};
   assign sp_inc = sp + 16'd1;
   assign op_req = op_t'(bus.op_code);
   // Upper return-address byte is forced to zero in 16-bit PC builds.
   assign pc_ext = pc22b ? {2'b00, bus.pc_in} : {8'h00, bus.pc_in[15:0]};

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state_q   <= S_IDLE;
         op_q      <= OP_PUSH;
         sh_q      <= '0;
         cnt_q     <= '0;
         asm_q     <= '0;
         rd_pend_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         asm_q     <= asm_d;
         rd_pend_q <= rd_pend_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      sh_d          = sh_q;
      cnt_d         = cnt_q;
      asm_d         = asm_q;
      rd_pend_d     = rd_pend_q;
      done_d        = done_q;

      op_ready      = 1'b0;
      sp_en         = 1'b0;
      sp_ndown_up   = 1'b0;
      ram_adr       = '0;
      ram_we        = 1'b0;
      ram_re        = 1'b0;
      ram_dout      = '0;
      pc_out        = '0;
      pc_load       = 1'b0;
      pop_data      = '0;
      pop_valid     = 1'b0;
      sreg_fl_in    = '0;
      sreg_fl_wr_en = '0;

      case (state_q)
         S_IDLE: begin
            op_ready = 1'b1;
            if (cp2en) begin
               done_d = 1'b0;
               if (bus.op_valid) begin
                  op_d      = op_req;
                  asm_d     = '0;
                  rd_pend_d = 1'b0;
                  case (op_req)
                     OP_PUSH: begin
                        sh_d    = {16'h0000, bus.push_data};
                        cnt_d   = 2'd1;
                        state_d = S_PUSH;
                     end
                     OP_POP: begin
                        cnt_d   = 2'd1;
                        state_d = S_POP;
                     end
                     OP_CALL, OP_IRQ: begin
                        sh_d    = pc_ext;
                        cnt_d   = N_ADDR;
                        state_d = S_PUSH;
                     end
                     OP_RET, OP_RETI: begin
                        cnt_d   = N_ADDR;
                        state_d = S_POP;
                     end
                     default: ;
                  endcase
               end
            end
         end

         S_PUSH: begin
            ram_adr  = sp;
            ram_dout = sh_q[7:0];
            if (cp2en) begin
               ram_we = 1'b1;
               sp_en  = 1'b1;
               if (op_q == OP_IRQ && cnt_q == 2'd1)
                  sreg_fl_wr_en[7] = 1'b1;
               sh_d  = {8'h00, sh_q[23:8]};
               cnt_d = cnt_q - 2'd1;
               if (cnt_q == 2'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         S_POP: begin
            ram_adr     = sp_inc;
            sp_ndown_up = 1'b1;
            if (cp2en) begin
               ram_re = 1'b1;
               sp_en  = 1'b1;
               // ram_din carries the byte requested one enabled cycle earlier.
               if (rd_pend_q)
                  asm_d = {asm_q[5:0], bus.ram_din};
               rd_pend_d = 1'b1;
               cnt_d     = cnt_q - 2'd1;
               if (cnt_q == 2'd1)
                  state_d = S_CAPT;
            end
         end

         S_CAPT: begin
            if (op_q == OP_POP) begin
               pop_data  = bus.ram_din;
               pop_valid = cp2en;
            end else begin
               pc_out  = {asm_q, bus.ram_din};
               pc_load = cp2en;
            end
            if (op_q == OP_RETI && cp2en) begin
               sreg_fl_wr_en[7] = 1'b1;
               sreg_fl_in[7]    = 1'b1;
            end
            if (cp2en) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.op_ready      = op_ready;
   assign bus.sp_en         = sp_en;
   assign bus.sp_ndown_up   = sp_ndown_up;
   assign bus.ram_adr       = ram_adr;
   assign bus.ram_we        = ram_we;
   assign bus.ram_re        = ram_re;
   assign bus.ram_dout      = ram_dout;
   assign bus.pc_out        = pc_out;
   assign bus.pc_load       = pc_load;
   assign bus.pop_data      = pop_data;
   assign bus.pop_valid     = pop_valid;
   assign bus.sreg_fl_in    = sreg_fl_in;
   assign bus.sreg_fl_wr_en = sreg_fl_wr_en;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = done_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboard bench: two sequencers (16- and 22-bit PC) share a SP/RAM model;
// stimulus queues expected bus events, a negedge monitor pops and compares them.
module tb_stack_op_sequencer;

   localparam int EV_WR  = 0;
   localparam int EV_RD  = 1;
   localparam int EV_SR  = 2;
   localparam int EV_PC  = 3;
   localparam int EV_POP = 4;

   typedef struct {
      int          kind;
      logic [15:0] adr;
      logic [23:0] val;
   } ev_t;

   logic cp2;
   logic ireset;
   logic cp2en;
   logic sel;

   logic        op_valid;
   logic [2:0]  op_code;
   logic [21:0] pc_in;
   logic [7:0]  push_data;

   logic [15:0] sp;
   logic        sp_ld;
   logic [15:0] sp_ld_val;
   logic [7:0]  rdata;
   logic [7:0]  mem [0:65535];

   logic        s_we, s_re, s_spen, s_dir;
   logic [15:0] s_adr;
   logic [7:0]  s_dout;

   logic        m_op_ready, m_busy, m_done;
   logic        m_we, m_re, m_spen, m_dir, m_pc_load, m_pop_valid;
   logic [15:0] m_adr;
   logic [7:0]  m_dout, m_pop_data, m_sr_in, m_sr_en;
   logic [21:0] m_pc_out;

   int   n_run, n_fail;
   int   mon_run, mon_fail;
   int   n_wr;
   ev_t  exp_q[$];

   stack_op_sequencer_if bus0 ();
   stack_op_sequencer_if bus1 ();

   stack_op_sequencer #(.pc22b(1'b0)) dut0 (
      .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .bus(bus0)
   );
   stack_op_sequencer #(.pc22b(1'b1)) dut1 (
      .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .bus(bus1)
   );

   assign bus0.op_valid  = op_valid & ~sel;
   assign bus1.op_valid  = op_valid & sel;
   assign bus0.op_code   = op_code;
   assign bus1.op_code   = op_code;
   assign bus0.pc_in     = pc_in;
   assign bus1.pc_in     = pc_in;
   assign bus0.push_data = push_data;
   assign bus1.push_data = push_data;
   assign bus0.spl_in    = sp[7:0];
   assign bus1.spl_in    = sp[7:0];
   assign bus0.sph_in    = sp[15:8];
   assign bus1.sph_in    = sp[15:8];
   assign bus0.ram_din   = rdata;
   assign bus1.ram_din   = rdata;

   assign m_op_ready  = sel ? bus1.op_ready      : bus0.op_ready;
   assign m_busy      = sel ? bus1.busy          : bus0.busy;
   assign m_done      = sel ? bus1.done          : bus0.done;
   assign m_we        = sel ? bus1.ram_we        : bus0.ram_we;
   assign m_re        = sel ? bus1.ram_re        : bus0.ram_re;
   assign m_spen      = sel ? bus1.sp_en         : bus0.sp_en;
   assign m_dir       = sel ? bus1.sp_ndown_up   : bus0.sp_ndown_up;
   assign m_adr       = sel ? bus1.ram_adr       : bus0.ram_adr;
   assign m_dout      = sel ? bus1.ram_dout      : bus0.ram_dout;
   assign m_pc_out    = sel ? bus1.pc_out        : bus0.pc_out;
   assign m_pc_load   = sel ? bus1.pc_load       : bus0.pc_load;
   assign m_pop_data  = sel ? bus1.pop_data      : bus0.pop_data;
   assign m_pop_valid = sel ? bus1.pop_valid     : bus0.pop_valid;
   assign m_sr_in     = sel ? bus1.sreg_fl_in    : bus0.sreg_fl_in;
   assign m_sr_en     = sel ? bus1.sreg_fl_wr_en : bus0.sreg_fl_wr_en;

   initial cp2 = 1'b0;
   always #5 cp2 = ~cp2;

   // Register-file SP and data RAM; strobes are captured mid-cycle, applied at the edge.
   always @(negedge cp2) begin
      s_we   <= m_we;
      s_re   <= m_re;
      s_spen <= m_spen;
      s_dir  <= m_dir;
      s_adr  <= m_adr;
      s_dout <= m_dout;
   end

   always @(posedge cp2) begin
      if (sp_ld)
         sp <= sp_ld_val;
      else if (s_spen)
         sp <= s_dir ? sp + 16'd1 : sp - 16'd1;
      if (s_we)
         mem[s_adr] <= s_dout;
      if (s_re)
         rdata <= mem[s_adr];
   end

   function automatic string kname(input int k);
      case (k)
         EV_WR:   return "ram_write";
         EV_RD:   return "ram_read";
         EV_SR:   return "sreg_write";
         EV_PC:   return "pc_load";
         default: return "pop_valid";
      endcase
   endfunction

   task automatic mon_ev(input int k, input logic [15:0] a, input logic [23:0] v);
      ev_t e;
      mon_run++;
      if (exp_q.size() == 0) begin
         mon_fail++;
         $display("FAIL unexpected_%s: got adr=%h val=%h, expected no event", kname(k), a, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.adr !== a || e.val !== v) begin
            mon_fail++;
            $display("FAIL %s: got %s adr=%h val=%h, expected %s adr=%h val=%h",
                     kname(k), kname(k), a, v, kname(e.kind), e.adr, e.val);
         end
      end
   endtask

   always @(negedge cp2) begin
      if (m_we) begin
         mon_ev(EV_WR, m_adr, {16'h0000, m_dout});
         n_wr++;
      end
      if (m_re)
         mon_ev(EV_RD, m_adr, 24'h0);
      if (m_sr_en != 8'h00)
         mon_ev(EV_SR, 16'h0, {8'h00, m_sr_en, m_sr_in});
      if (m_pc_load)
         mon_ev(EV_PC, 16'h0, {2'b00, m_pc_out});
      if (m_pop_valid)
         mon_ev(EV_POP, 16'h0, {16'h0000, m_pop_data});
   end

   task automatic expect_ev(input int k, input logic [15:0] a, input logic [23:0] v);
      ev_t e;
      e.kind = k;
      e.adr  = a;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge cp2);
      #1;
   endtask

   task automatic load_sp(input logic [15:0] v);
      sp_ld_val = v;
      sp_ld     = 1'b1;
      tick();
      sp_ld     = 1'b0;
   endtask

   task automatic accept(input string name, input logic [2:0] code,
                         input logic [21:0] pc, input logic [7:0] pd);
      chk({name, "_op_ready"}, 32'(m_op_ready), 32'd1);
      op_code   = code;
      pc_in     = pc;
      push_data = pd;
      op_valid  = 1'b1;
      tick();
      op_valid  = 1'b0;
      chk({name, "_busy"}, 32'(m_busy), 32'd1);
      chk({name, "_op_ready_busy"}, 32'(m_op_ready), 32'd0);
   endtask

   task automatic finish_op(input string name, input int lat0, input int exp_lat,
                            input logic [15:0] exp_sp);
      int lat;
      lat = lat0;
      while (!m_done && lat < 20) begin
         tick();
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_sp"}, 32'(sp), 32'(exp_sp));
      chk({name, "_busy_end"}, 32'(m_busy), 32'd0);
      tick();
      chk({name, "_done_clear"}, 32'(m_done), 32'd0);
   endtask

   task automatic run_op(input string name, input logic [2:0] code, input logic [21:0] pc,
                         input logic [7:0] pd, input int exp_lat, input logic [15:0] exp_sp);
      accept(name, code, pc, pd);
      finish_op(name, 0, exp_lat, exp_sp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      int lat;
      n_run = 0; n_fail = 0; mon_run = 0; mon_fail = 0; n_wr = 0;
      ireset = 1'b0; cp2en = 1'b1; sel = 1'b0;
      op_valid = 1'b0; op_code = 3'd0; pc_in = '0; push_data = '0;
      sp_ld = 1'b0; sp_ld_val = '0; sp = 16'h04FF; rdata = '0;
      #1;
      chk("rst_op_ready", 32'(m_op_ready), 32'd1);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_strobes", {26'h0, m_we, m_re, m_spen, m_pc_load, m_pop_valid, |m_sr_en}, 32'd0);
      chk("rst_ram_adr", 32'(m_adr), 32'd0);
      chk("rst_pc_out", 32'(m_pc_out), 32'd0);
      tick();
      load_sp(16'h04FF);
      ireset = 1'b1;
      tick();

      expect_ev(EV_WR, 16'h04FF, 24'h34);
      expect_ev(EV_WR, 16'h04FE, 24'h12);
      run_op("call_1234", 3'd2, 22'h001234, 8'h00, 2, 16'h04FD);

      expect_ev(EV_RD, 16'h04FE, 24'h0);
      expect_ev(EV_RD, 16'h04FF, 24'h0);
      expect_ev(EV_PC, 16'h0, 24'h001234);
      run_op("ret_1234", 3'd3, 22'h0, 8'h00, 3, 16'h04FF);

      // Bits [21:16] must be dropped by the 16-bit PC build.
      expect_ev(EV_WR, 16'h04FF, 24'h78);
      expect_ev(EV_WR, 16'h04FE, 24'h56);
      run_op("call_hi_ign", 3'd2, 22'h3F5678, 8'h00, 2, 16'h04FD);

      expect_ev(EV_RD, 16'h04FE, 24'h0);
      expect_ev(EV_RD, 16'h04FF, 24'h0);
      expect_ev(EV_PC, 16'h0, 24'h005678);
      run_op("ret_5678", 3'd3, 22'h0, 8'h00, 3, 16'h04FF);

      load_sp(16'h0000);
      expect_ev(EV_WR, 16'h0000, 24'hA5);
      run_op("push_wrap", 3'd0, 22'h0, 8'hA5, 1, 16'hFFFF);

      expect_ev(EV_RD, 16'h0000, 24'h0);
      expect_ev(EV_POP, 16'h0, 24'hA5);
      run_op("pop_wrap", 3'd1, 22'h0, 8'h00, 2, 16'h0000);

      load_sp(16'h04FF);
      wr0 = n_wr;
      expect_ev(EV_WR, 16'h04FF, 24'h34);
      expect_ev(EV_WR, 16'h04FE, 24'h12);
      accept("call_stall", 3'd2, 22'h001234, 8'h00);
      tick();
      cp2en = 1'b0;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_strobes", {29'h0, m_we, m_spen, m_re}, 32'd0);
         chk("stall_busy", 32'(m_busy), 32'd1);
         tick();
         lat++;
      end
      cp2en = 1'b1;
      finish_op("call_stall", lat, 5, 16'h04FD);
      chk("stall_write_count", 32'(n_wr - wr0), 32'd2);

      load_sp(16'h04FD);
      expect_ev(EV_RD, 16'h04FE, 24'h0);
      accept("ret_reset", 3'd3, 22'h0, 8'h00);
      tick();
      ireset = 1'b0;
      #1;
      chk("midrst_strobes", {29'h0, m_re, m_spen, m_pc_load}, 32'd0);
      chk("midrst_busy", 32'(m_busy), 32'd0);
      tick();
      tick();
      ireset = 1'b1;
      tick();
      chk("midrst_op_ready", 32'(m_op_ready), 32'd1);
      chk("midrst_done", 32'(m_done), 32'd0);

      op_code  = 3'd6;
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("rsv_busy", 32'(m_busy), 32'd0);
         chk("rsv_done", 32'(m_done), 32'd0);
         tick();
      end

      sel = 1'b1;
      load_sp(16'h04FF);
      expect_ev(EV_WR, 16'h04FF, 24'hDE);
      expect_ev(EV_WR, 16'h04FE, 24'hBC);
      expect_ev(EV_WR, 16'h04FD, 24'h2A);
      expect_ev(EV_SR, 16'h0, 24'h008000);
      run_op("irq_22b", 3'd4, 22'h2ABCDE, 8'h00, 3, 16'h04FC);

      expect_ev(EV_RD, 16'h04FD, 24'h0);
      expect_ev(EV_RD, 16'h04FE, 24'h0);
      expect_ev(EV_RD, 16'h04FF, 24'h0);
      expect_ev(EV_SR, 16'h0, 24'h008080);
      expect_ev(EV_PC, 16'h0, 24'h2ABCDE);
      run_op("reti_22b", 3'd5, 22'h0, 8'h00, 4, 16'h04FF);

      tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      n_run  = n_run + mon_run;
      n_fail = n_fail + mon_fail;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
